ddr_burst_sched: RTL and testbench
==================================

# ddr_burst_sched

Burst scheduler that shares one DDR3 controller command port between the image write path and the display read path. It grants fixed-length 128-bit bursts to each side in round-robin order, generates ping-pong frame-buffer addresses, and tracks which bank holds the last complete frame. It sits between the PCIe image receive/pack stage (writer), the display fetch stage (reader), and the DDR controller user interface.

## Interface
- BURST_LEN, 64: 128-bit beats per burst, power of two.
- ADDR_W, 28: DDR command address width.
- ADDR_STEP, 8: address units per 128-bit beat.
- FRAME_BURSTS, 4096: bursts per frame bank, power of two.
- BANK0_BASE, 28'h000_0000 / BANK1_BASE, 28'h080_0000: bank base addresses.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  synchronous, active-low reset.
- WR_REQ  in  1  writer holds ≥BURST_LEN beats (level).
- WR_GNT  out  1  one-cycle grant; writer then sends exactly BURST_LEN beats.
- WR_EN  in  1  writer beat strobe.
- WR_FRAME_END  in  1  pulse: frame's last burst handed over.
- RD_REQ  in  1  reader has space for BURST_LEN beats (level).
- RD_GNT  out  1  one-cycle read grant.
- RD_FRAME_SYNC  in  1  pulse: reader starting a new frame.
- DDR_RD_VALID  in  1  read beat returned by controller.
- CMD_EN  out  1  command valid.
- CMD_RDY  in  1  controller accepts when CMD_EN & CMD_RDY.
- CMD_WR  out  1  1 = write, 0 = read.
- CMD_ADDR  out  ADDR_W  burst start address.
- WR_BANK / RD_BANK  out  1  active bank for each side.
- FRAME_VALID  out  1  at least one complete frame stored.
- ERR  out  1  sticky protocol error.

## Operation
- FSM states: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA.
- In IDLE, pick a requester. Eligible: WR_REQ, and RD_REQ & FRAME_VALID. If both are eligible, serve the side not served last (write first after reset).
- Entering WR_CMD or RD_CMD: the grant pulses for one cycle on the entry cycle. CMD_EN stays high from entry until the handshake.
- After the handshake, move to *_DATA (stay there if beats remain).
- Write beats are counted from the grant cycle onward, including before command acceptance.
- Leave WR_* when the command has been accepted and BURST_LEN WR_EN beats have been counted. Leave RD_* when the command has been accepted and BURST_LEN DDR_RD_VALID beats have been counted.
- Addressing:
  - CMD_ADDR = base(bank) + idx·BURST_LEN·ADDR_STEP, computed modulo 2^ADDR_W.
  - idx is a per-side burst index of width log2(FRAME_BURSTS). It increments after each completed burst and wraps to 0 at FRAME_BURSTS.
- Writer frame end:
  - WR_FRAME_END is latched sticky.
  - It is applied when the current write burst completes, or immediately in IDLE.
  - Applying it: the write index goes to 0, WR_BANK toggles, last_done ← old WR_BANK, and FRAME_VALID is set.
- Reader frame sync:
  - RD_FRAME_SYNC is latched sticky and applied at the same points.
  - Applying it: the read index goes to 0 and RD_BANK ← last_done.
- Two banks only. Tearing is possible when the writer laps the reader; this is accepted.
- ERR is set by any of:
  - a WR_EN outside WR_CMD/WR_DATA;
  - a WR_EN beyond BURST_LEN within a burst;
  - a DDR_RD_VALID outside RD_*.

  Offending beats are not counted. ERR clears only on reset.

## Timing
- Reset values:
  - all outputs 0, CMD_ADDR = BANK0_BASE;
  - WR_BANK = RD_BANK = 0;
  - indices 0, sticky flags 0, round-robin pointer set to write.
- Reset mid-burst abandons the burst on the next edge. No completion side effects occur.
- Request sampled in IDLE at edge n → grant and CMD_EN high in cycle n+1.
- Burst completing at edge m → state IDLE in cycle m+1. The earliest next grant is in cycle m+2, so the minimum spacing between grants is one IDLE cycle.
- CMD_ADDR and CMD_WR are registered and stable while CMD_EN is high.
- WR_FRAME_END coincident with the final beat: the bank toggle is visible in the cycle after completion, and the next write burst uses the new bank at idx 0.
- RD_FRAME_SYNC while FRAME_VALID = 0: the read index resets, RD_BANK stays 0.

## Structure
- Shared package ddr_sched_pkg holds:
  - the state enum;
  - derived widths IDX_W = log2(FRAME_BURSTS) and BEAT_W = log2(BURST_LEN)+1;
  - the burst byte-offset constant BURST_LEN·ADDR_STEP.
- Sub-module fb_addr_gen is instantiated once per side. It holds the bank bit, burst index and sticky frame flag, and has these ports:
  - inputs: advance and frame-event;
  - outputs: address and bank.

## Test plan
- Write only, WR_REQ held: 3 grants. CMD_ADDR must be 0x0, 0x200, 0x400, with CMD_WR = 1 and 64 beats each.
- WR_REQ and RD_REQ both held after one frame: grants must alternate W,R,W,R, and read addresses must come from bank 0.
- FRAME_BURSTS = 4: write 4 bursts plus WR_FRAME_END on the last beat. Required result: WR_BANK = 1, FRAME_VALID = 1, next write address = BANK1_BASE.
- CMD_RDY held low 10 cycles while all 64 beats arrive: CMD_EN stays high, and return to IDLE occurs only after acceptance.
- Inject a 65th WR_EN in one burst, and a DDR_RD_VALID in IDLE: ERR = 1 and the beat counts are unchanged.
- Pull RST low mid-read-burst for one cycle: all outputs at reset values on the next cycle, and the next grant goes to write.

Source files
------------

// File: rtl/ddr_sched_pkg.sv
// ddr_sched_pkg: shared state encoding and width/offset helpers for the DDR burst scheduler
package ddr_sched_pkg;
  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;
  function automatic int unsigned idx_w(input int unsigned frame_bursts);
    return frame_bursts > 1 ? $clog2(frame_bursts) : 1;
  endfunction
  function automatic int unsigned beat_w(input int unsigned burst_len);
    return $clog2(burst_len) + 1;
  endfunction
  function automatic int unsigned burst_off(input int unsigned burst_len, input int unsigned addr_step);
    return burst_len * addr_step;
  endfunction
endpackage

// File: rtl/ddr_burst_sched_fb_addr_gen.sv
// fb_addr_gen: per-side ping-pong bank bit, burst index and sticky frame-event flag
module fb_addr_gen #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned IDX_W = 12,
  parameter int unsigned BURST_OFF = 512,
  parameter logic [ADDR_W-1:0] BASE0 = '0,
  parameter logic [ADDR_W-1:0] BASE1 = '0
) (
  input  logic CLK,
  input  logic RST,
  input  logic adv,
  input  logic evt,
  input  logic idle,
  input  logic new_bank,
  output logic [ADDR_W-1:0] addr,
  output logic bank
);
  logic [IDX_W-1:0] idx;
  logic pend, pending, fire;
  // addr already reflects a frame event applied this cycle so an IDLE grant uses the new bank
  always_comb begin
    pending = pend | evt;
    fire = pending & (adv | idle);
    addr = fire ? (new_bank ? BASE1 : BASE0) : (bank ? BASE1 : BASE0) + ADDR_W'(idx) * ADDR_W'(BURST_OFF);
  end
  always_ff @(posedge CLK)
    if (!RST) begin
      idx <= '0;
      bank <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= pending & ~fire;
      if (fire) begin
        idx <= '0;
        bank <= new_bank;
      end else if (adv) idx <= idx + IDX_W'(1);
    end
endmodule

// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched: round-robin burst arbiter sharing one DDR command port between writer and reader
import ddr_sched_pkg::*;
module ddr_burst_sched #(
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned FRAME_BURSTS = 4096,
  parameter logic [ADDR_W-1:0] BANK0_BASE = 28'h000_0000,
  parameter logic [ADDR_W-1:0] BANK1_BASE = 28'h080_0000
) (
  input  logic CLK,
  input  logic RST,
  input  logic WR_REQ,
  output logic WR_GNT,
  input  logic WR_EN,
  input  logic WR_FRAME_END,
  input  logic RD_REQ,
  output logic RD_GNT,
  input  logic RD_FRAME_SYNC,
  input  logic DDR_RD_VALID,
  output logic CMD_EN,
  input  logic CMD_RDY,
  output logic CMD_WR,
  output logic [ADDR_W-1:0] CMD_ADDR,
  output logic WR_BANK,
  output logic RD_BANK,
  output logic FRAME_VALID,
  output logic ERR
);
  localparam int unsigned IW = idx_w(FRAME_BURSTS);
  localparam int unsigned BW = beat_w(BURST_LEN);
  localparam int unsigned OFF = burst_off(BURST_LEN, ADDR_STEP);
  localparam logic [BW-1:0] FULL = BW'(BURST_LEN);
  state_t state;
  logic [BW-1:0] beats, beats_n;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic pref_wr, seen, last_done;
  logic is_idle, in_wr, in_rd, wr_ok, rd_ok, acc, cmd_ok, done, go_wr, go_rd;
  // the writer toggles banks on every frame end, so the last complete frame is always the other bank
  always_comb begin
    FRAME_VALID = seen | WR_BANK;
    last_done = FRAME_VALID & ~WR_BANK;
    is_idle = state == IDLE;
    in_wr = state == WR_CMD || state == WR_DATA;
    in_rd = state == RD_CMD || state == RD_DATA;
    wr_ok = in_wr & WR_EN & (beats != FULL);
    rd_ok = in_rd & DDR_RD_VALID & (beats != FULL);
    beats_n = beats + BW'(wr_ok | rd_ok);
    acc = CMD_EN & CMD_RDY;
    cmd_ok = state == WR_DATA || state == RD_DATA || acc;
    done = (in_wr | in_rd) & cmd_ok & (beats_n == FULL);
    go_wr = is_idle & WR_REQ & (pref_wr | ~(RD_REQ & FRAME_VALID));
    go_rd = is_idle & RD_REQ & FRAME_VALID & ~go_wr;
  end
  fb_addr_gen #(.ADDR_W(ADDR_W), .IDX_W(IW), .BURST_OFF(OFF), .BASE0(BANK0_BASE), .BASE1(BANK1_BASE)) u_wr (
    .CLK, .RST, .adv(done & in_wr), .evt(WR_FRAME_END), .idle(is_idle),
    .new_bank(~WR_BANK), .addr(wr_addr), .bank(WR_BANK)
  );
  fb_addr_gen #(.ADDR_W(ADDR_W), .IDX_W(IW), .BURST_OFF(OFF), .BASE0(BANK0_BASE), .BASE1(BANK1_BASE)) u_rd (
    .CLK, .RST, .adv(done & in_rd), .evt(RD_FRAME_SYNC), .idle(is_idle),
    .new_bank(last_done), .addr(rd_addr), .bank(RD_BANK)
  );
  always_ff @(posedge CLK)
    if (!RST) begin
      state <= IDLE;
      beats <= '0;
      pref_wr <= 1'b1;
      seen <= 1'b0;
      ERR <= 1'b0;
      WR_GNT <= 1'b0;
      RD_GNT <= 1'b0;
      CMD_EN <= 1'b0;
      CMD_WR <= 1'b0;
      CMD_ADDR <= BANK0_BASE;
    end else begin
      WR_GNT <= go_wr;
      RD_GNT <= go_rd;
      seen <= seen | WR_BANK;
      ERR <= ERR | (WR_EN & ~wr_ok) | (DDR_RD_VALID & ~in_rd);
      beats <= (go_wr | go_rd) ? '0 : beats_n;
      if (go_wr | go_rd) begin
        state <= go_wr ? WR_CMD : RD_CMD;
        CMD_EN <= 1'b1;
        CMD_WR <= go_wr;
        CMD_ADDR <= go_wr ? wr_addr : rd_addr;
        pref_wr <= go_rd;
      end else if (done) begin
        state <= IDLE;
        CMD_EN <= 1'b0;
      end else if (acc) begin
        state <= in_wr ? WR_DATA : RD_DATA;
        CMD_EN <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ddr_burst_sched.sv
// tb_ddr_burst_sched: transaction-level reference model checking grants, addresses, banks and errors
module tb_ddr_burst_sched;
  localparam int BL = 64;
  localparam int FB = 4;
  localparam int OFF = BL * 8;
  localparam logic [27:0] B1 = 28'h080_0000;
  logic clk = 0, rst = 0;
  logic wr_req = 0, wr_en = 0, wr_frame_end = 0, rd_req = 0, rd_frame_sync = 0, ddr_rd_valid = 0, cmd_rdy = 0;
  logic wr_gnt, rd_gnt, cmd_en, cmd_wr, wr_bank, rd_bank, frame_valid, err;
  logic [27:0] cmd_addr;
  int total = 0, bad = 0;
  int m_widx, m_ridx;
  bit m_wb, m_rb, m_fv, m_last, m_pref, m_err;
  always #5 clk = ~clk;
  ddr_burst_sched #(.FRAME_BURSTS(FB)) dut (
    .CLK(clk), .RST(rst), .WR_REQ(wr_req), .WR_GNT(wr_gnt), .WR_EN(wr_en), .WR_FRAME_END(wr_frame_end),
    .RD_REQ(rd_req), .RD_GNT(rd_gnt), .RD_FRAME_SYNC(rd_frame_sync), .DDR_RD_VALID(ddr_rd_valid),
    .CMD_EN(cmd_en), .CMD_RDY(cmd_rdy), .CMD_WR(cmd_wr), .CMD_ADDR(cmd_addr),
    .WR_BANK(wr_bank), .RD_BANK(rd_bank), .FRAME_VALID(frame_valid), .ERR(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [27:0] addr_of(input bit b, input int idx);
    return (b ? B1 : 28'h0) + 28'(idx * OFF);
  endfunction
  task automatic model_reset();
    m_widx = 0; m_ridx = 0; m_wb = 0; m_rb = 0; m_fv = 0; m_last = 0; m_pref = 1; m_err = 0;
  endtask
  task automatic chk_reset_vals();
    chk("rst_wr_gnt", wr_gnt, 0); chk("rst_rd_gnt", rd_gnt, 0); chk("rst_cmd_en", cmd_en, 0);
    chk("rst_cmd_wr", cmd_wr, 0); chk("rst_cmd_addr", cmd_addr, 0); chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 0); chk("rst_fv", frame_valid, 0); chk("rst_err", err, 0);
  endtask
  task automatic pulse_reset();
    @(negedge clk); rst = 0;
    @(negedge clk); chk_reset_vals(); rst = 1;
    model_reset();
  endtask
  // request, grant, burst transfer and completion; called at a negedge with the DUT idle
  task automatic burst(input bit wq, input bit rq, input int rdy_dly, input bit fe, input bit fs,
                       input bit gaps, input int extra, input int lit);
    bit exp_wr, accd, beat;
    int lat, sent, c;
    logic [27:0] ea;
    exp_wr = wq && (!(rq && m_fv) || m_pref);
    ea = exp_wr ? addr_of(m_wb, m_widx) : addr_of(m_rb, m_ridx);
    wr_req = wq; rd_req = rq;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(wr_gnt | rd_gnt) && lat < 4);
    wr_req = 0; rd_req = 0;
    chk("gnt_latency", lat, 1);
    if (!(wr_gnt | rd_gnt)) return;
    chk("wr_gnt", wr_gnt, exp_wr); chk("rd_gnt", rd_gnt, !exp_wr); chk("cmd_wr", cmd_wr, exp_wr);
    chk("cmd_addr", cmd_addr, ea); chk("rd_bank", rd_bank, m_rb); chk("wr_bank", wr_bank, m_wb);
    if (lit >= 0) chk("cmd_addr_lit", cmd_addr, lit);
    accd = 0; sent = 0; c = 0;
    while (!(accd && sent >= BL)) begin
      chk("cmd_en_hold", cmd_en, !accd);
      beat = (sent < BL + (exp_wr ? extra : 0)) && (!gaps || $urandom_range(3) != 0);
      cmd_rdy = c >= rdy_dly;
      wr_en = exp_wr && beat;
      ddr_rd_valid = !exp_wr && beat;
      wr_frame_end = exp_wr && fe && beat && sent == BL - 1;
      rd_frame_sync = fs && c == 3;
      @(posedge clk);
      if (beat) sent++;
      if (cmd_rdy) accd = 1;
      @(negedge clk);
      c++;
      if (c > 3000) begin chk("burst_timeout", c, 0); break; end
    end
    wr_en = 0; ddr_rd_valid = 0; wr_frame_end = 0; rd_frame_sync = 0; cmd_rdy = 0;
    if (exp_wr) begin
      if (fe) begin m_last = m_wb; m_wb = !m_wb; m_widx = 0; m_fv = 1; end
      else m_widx = (m_widx + 1) % FB;
      if (extra > 0) m_err = 1;
    end else if (!fs) m_ridx = (m_ridx + 1) % FB;
    if (fs) begin m_ridx = 0; m_rb = m_last; end
    m_pref = !exp_wr;
    chk("done_cmd_en", cmd_en, 0); chk("done_gnt", wr_gnt | rd_gnt, 0);
    chk("done_wr_bank", wr_bank, m_wb); chk("done_fv", frame_valid, m_fv); chk("done_err", err, m_err);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    bit wq, rq;
    int lat;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1;
    burst(1, 0, 0, 0, 0, 0, 0, 'h0);
    burst(1, 0, 5, 0, 0, 1, 0, 'h200);
    burst(1, 0, 0, 0, 0, 0, 0, 'h400);
    burst(1, 0, 2, 1, 0, 0, 0, 'h600);
    chk("frame_bank_lit", wr_bank, 1); chk("frame_valid_lit", frame_valid, 1);
    burst(1, 0, 0, 0, 0, 0, 0, 'h080_0000);
    burst(1, 1, 0, 0, 0, 0, 0, 'h0);
    burst(1, 1, 0, 0, 0, 0, 0, 'h080_0200);
    burst(1, 1, 3, 0, 0, 1, 0, 'h200);
    burst(1, 1, 0, 0, 0, 0, 0, 'h080_0400);
    burst(1, 0, 74, 0, 0, 0, 0, 'h080_0600);
    for (int i = 0; i < 30; i++) begin
      wq = $urandom_range(1); rq = $urandom_range(1);
      if (!wq && !(rq && m_fv)) wq = 1;
      burst(wq, rq, $urandom_range(90), $urandom_range(4) == 0, $urandom_range(5) == 0, $urandom_range(1), 0, -1);
    end
    if (!m_fv) burst(1, 0, 0, 1, 0, 0, 0, -1);
    rd_req = 1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rd_gnt && lat < 4);
    rd_req = 0;
    chk("midrst_rd_gnt", rd_gnt, 1);
    cmd_rdy = 1; ddr_rd_valid = 1;
    repeat (10) @(negedge clk);
    cmd_rdy = 0; ddr_rd_valid = 0; rst = 0;
    @(negedge clk);
    chk_reset_vals();
    rst = 1;
    model_reset();
    burst(1, 1, 0, 0, 0, 0, 0, 'h0);
    @(negedge clk); ddr_rd_valid = 1;
    @(negedge clk); ddr_rd_valid = 0;
    chk("err_rd_idle", err, 1);
    pulse_reset();
    burst(1, 0, 70, 0, 0, 0, 1, 'h0);
    chk("err_extra_beat", err, 1);
    burst(1, 0, 0, 0, 1, 0, 0, 'h200);
    chk("err_sticky", err, 1);
    chk("sync_no_frame_rd_bank", rd_bank, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
